// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues in-order fetch requests to the
// instruction SRAM-like bridge, tracks live and stale outstanding requests,
// and buffers returned instructions (or ADEF slots) for the ID stage.
module if_fetch_queue #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned INST_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h1c00_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_redirect_valid,
  input  logic [ADDR_W-1:0] wb_redirect_pc,
  input  logic              br_redirect_valid,
  input  logic [ADDR_W-1:0] br_redirect_pc,
  input  logic              fetch_stall,
  output logic              inst_sram_req,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_adef
);

  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ICW = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned IPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic              adef;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } slot_t;

  function automatic logic [IPW-1:0] ibuf_inc(input logic [IPW-1:0] p);
    return (p == IPW'(IBUF_DEPTH - 1)) ? '0 : p + IPW'(1);
  endfunction

  function automatic logic [OPW-1:0] pcq_inc(input logic [OPW-1:0] p);
    return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + OPW'(1);
  endfunction

  logic [ADDR_W-1:0] fetch_pc;
  logic [OCW-1:0]    live_cnt;
  logic [OCW-1:0]    discard_cnt;
  logic              adef_hold;

  slot_t             ibuf [IBUF_DEPTH];
  logic [ICW-1:0]    ibuf_count;
  logic [IPW-1:0]    ibuf_head;
  logic [IPW-1:0]    ibuf_tail;

  logic [ADDR_W-1:0] pcq [MAX_OUTSTANDING];
  logic [OPW-1:0]    pcq_head;
  logic [OPW-1:0]    pcq_tail;

  logic              redirect_any;
  logic [ADDR_W-1:0] redirect_pc;
  logic              pc_misaligned;
  logic              issue_base;
  logic              outstanding_ok;
  logic              ibuf_room_ok;
  logic              accept;
  logic              resp_any;
  logic              resp_stale;
  logic              resp_live;
  logic              adef_push;
  logic              push;
  logic              pop;
  slot_t             push_slot;
  slot_t             head_slot;

  // Request/response qualification and IBUF push selection
  always_comb begin
    redirect_any   = wb_redirect_valid | br_redirect_valid;
    redirect_pc    = wb_redirect_valid ? wb_redirect_pc : br_redirect_pc;
    pc_misaligned  = |fetch_pc[1:0];
    issue_base     = ~reset & ~fetch_stall & ~adef_hold & ~redirect_any;
    outstanding_ok = ((OCW+1)'(live_cnt) + (OCW+1)'(discard_cnt)) < (OCW+1)'(MAX_OUTSTANDING);
    ibuf_room_ok   = (32'(live_cnt) + 32'(ibuf_count)) < IBUF_DEPTH;
    inst_sram_req  = issue_base & ~pc_misaligned & outstanding_ok & ibuf_room_ok;
    inst_sram_addr = fetch_pc;
    accept         = inst_sram_req & inst_sram_addr_ok;
    // A response with nothing outstanding is a bridge protocol error and is ignored
    resp_stale     = inst_sram_data_ok & (discard_cnt != '0);
    resp_live      = inst_sram_data_ok & (discard_cnt == '0) & (live_cnt != '0);
    resp_any       = resp_stale | resp_live;
    adef_push      = issue_base & pc_misaligned & (live_cnt == '0) &
                     (ibuf_count != ICW'(IBUF_DEPTH));
    pop            = id_valid & id_ready;
    push           = (resp_live & ~redirect_any) | adef_push;
    push_slot.adef = adef_push;
    push_slot.pc   = adef_push ? fetch_pc : pcq[pcq_head];
    push_slot.inst = adef_push ? '0 : inst_sram_rdata;
  end

  // ID-side view of the IBUF head; zeroed while empty
  always_comb begin
    head_slot = ibuf[ibuf_head];
    id_valid  = (ibuf_count != '0);
    id_inst   = id_valid ? head_slot.inst : '0;
    id_pc     = id_valid ? head_slot.pc   : '0;
    id_adef   = id_valid & head_slot.adef;
  end

  // Control state: PC, outstanding counters, FIFO pointers, ADEF hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      live_cnt    <= '0;
      discard_cnt <= '0;
      adef_hold   <= 1'b0;
      ibuf_count  <= '0;
      ibuf_head   <= '0;
      ibuf_tail   <= '0;
      pcq_head    <= '0;
      pcq_tail    <= '0;
    end else begin
      if (accept)   pcq_tail <= pcq_inc(pcq_tail);
      if (resp_any) pcq_head <= pcq_inc(pcq_head);
      if (redirect_any) begin
        fetch_pc    <= redirect_pc;
        adef_hold   <= 1'b0;
        live_cnt    <= '0;
        discard_cnt <= discard_cnt + live_cnt - OCW'(resp_any);
        ibuf_count  <= '0;
        ibuf_head   <= '0;
        ibuf_tail   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
        adef_hold   <= adef_hold | adef_push;
        live_cnt    <= live_cnt + OCW'(accept) - OCW'(resp_live);
        discard_cnt <= discard_cnt - OCW'(resp_stale);
        ibuf_count  <= ibuf_count + ICW'(push) - ICW'(pop);
        if (pop)  ibuf_head <= ibuf_inc(ibuf_head);
        if (push) ibuf_tail <= ibuf_inc(ibuf_tail);
      end
    end
  end

  // Payload storage: request PCs on accept, IBUF slots on push
  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_tail] <= fetch_pc;
    if (push)   ibuf[ibuf_tail] <= push_slot;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order memory responder model.
module tb_if_fetch_queue;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_redirect_valid;
  logic [31:0] wb_redirect_pc;
  logic        br_redirect_valid;
  logic [31:0] br_redirect_pc;
  logic        fetch_stall;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_adef;

  logic [31:0] mem_q [$];
  logic [31:0] acc_q [$];
  item_t       pop_q [$];
  logic        mem_en;
  logic        last_req;
  logic [31:0] last_addr;
  logic        last_valid;
  int          n_cmp = 0;
  int          n_err = 0;

  if_fetch_queue dut (
    .clk               (clk),
    .reset             (reset),
    .wb_redirect_valid (wb_redirect_valid),
    .wb_redirect_pc    (wb_redirect_pc),
    .br_redirect_valid (br_redirect_valid),
    .br_redirect_pc    (br_redirect_pc),
    .fetch_stall       (fetch_stall),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_valid          (id_valid),
    .id_ready          (id_ready),
    .id_inst           (id_inst),
    .id_pc             (id_pc),
    .id_adef           (id_adef)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic item_t pop_at(input int i);
    item_t none;
    none = 'x;
    return (i < pop_q.size()) ? pop_q[i] : none;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the responder, log handshakes just before the edge, return at negedge
  task automatic tick();
    item_t it;
    inst_sram_data_ok = mem_en && (mem_q.size() != 0);
    inst_sram_rdata   = inst_sram_data_ok ? inst_of(mem_q[0]) : 32'h0;
    #1;
    last_req   = inst_sram_req;
    last_addr  = inst_sram_addr;
    last_valid = id_valid;
    if (inst_sram_data_ok) void'(mem_q.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) begin
      mem_q.push_back(inst_sram_addr);
      acc_q.push_back(inst_sram_addr);
    end
    if (id_valid && id_ready) begin
      it.adef = id_adef;
      it.pc   = id_pc;
      it.inst = id_inst;
      pop_q.push_back(it);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    fetch_stall = 1'b1;
    mem_en      = 1'b1;
    id_ready    = 1'b1;
    repeat (8) tick();
    fetch_stall = 1'b0;
    acc_q.delete();
    pop_q.delete();
  endtask

  task automatic br_redirect(input logic [31:0] pc);
    br_redirect_valid = 1'b1;
    br_redirect_pc    = pc;
    tick();
    br_redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wb_redirect_valid = 1'b0; wb_redirect_pc = 32'h0;
    br_redirect_valid = 1'b0; br_redirect_pc = 32'h0;
    fetch_stall = 1'b0; inst_sram_addr_ok = 1'b1;
    inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    id_ready = 1'b1; mem_en = 1'b1;

    // Reset values
    @(negedge clk); #1;
    chk("rst_req", 32'(inst_sram_req), 32'd0);
    chk("rst_addr", inst_sram_addr, 32'h1c00_0000);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_adef", 32'(id_adef), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming at one instruction per cycle
    tick();
    chk("t1_first_req", 32'(last_req), 32'd1);
    chk("t1_first_addr", last_addr, 32'h1c00_0000);
    tick();
    chk("t1_valid_c2", 32'(last_valid), 32'd0);
    tick();
    chk("t1_valid_c3", 32'(last_valid), 32'd1);
    repeat (7) tick();
    chk("t1_acc_n", 32'(acc_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) chk("t1_acc", acc_at(i), 32'h1c00_0000 + 32'(4 * i));
    chk("t1_pop_n", 32'(pop_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_pop_pc", pop_at(i).pc, 32'h1c00_0000 + 32'(4 * i));
      chk("t1_pop_inst", pop_at(i).inst, inst_of(32'h1c00_0000 + 32'(4 * i)));
      chk("t1_pop_adef", 32'(pop_at(i).adef), 32'd0);
    end
    drain();

    // ID back-pressure: IBUF fills with exactly four, then drains in order
    id_ready = 1'b0;
    repeat (8) tick();
    chk("t2_acc_n", 32'(acc_q.size()), 32'd4);
    chk("t2_req_blocked", 32'(last_req), 32'd0);
    chk("t2_pop_n", 32'(pop_q.size()), 32'd0);
    chk("t2_head_valid", 32'(id_valid), 32'd1);
    chk("t2_head_pc", id_pc, 32'h1c00_0028);
    chk("t2_head_inst", id_inst, inst_of(32'h1c00_0028));
    id_ready = 1'b1;
    acc_q.delete();
    repeat (8) tick();
    for (int i = 0; i < 4; i++) chk("t2_drain_pc", pop_at(i).pc, 32'h1c00_0028 + 32'(4 * i));
    chk("t2_resume_addr", acc_at(0), 32'h1c00_0038);
    drain();

    // Branch redirect with three requests in flight: stale data dropped
    mem_en = 1'b0;
    repeat (3) tick();
    chk("t3_acc_n", 32'(acc_q.size()), 32'd3);
    br_redirect(32'h1c00_0100);
    chk("t3_redirect_req", 32'(last_req), 32'd0);
    acc_q.delete();
    tick();
    chk("t3_new_req", 32'(last_req), 32'd1);
    chk("t3_new_addr", last_addr, 32'h1c00_0100);
    fetch_stall = 1'b1;
    mem_en = 1'b1;
    repeat (8) tick();
    chk("t3_pop_n", 32'(pop_q.size()), 32'd1);
    chk("t3_pop_pc", pop_at(0).pc, 32'h1c00_0100);
    chk("t3_pop_inst", pop_at(0).inst, inst_of(32'h1c00_0100));
    drain();

    // Simultaneous WB and branch redirect: WB wins
    wb_redirect_valid = 1'b1; wb_redirect_pc = 32'h1c00_8000;
    br_redirect_valid = 1'b1; br_redirect_pc = 32'h1c00_0200;
    tick();
    chk("t4_redirect_req", 32'(last_req), 32'd0);
    wb_redirect_valid = 1'b0; br_redirect_valid = 1'b0;
    tick();
    chk("t4_req", 32'(last_req), 32'd1);
    chk("t4_addr", last_addr, 32'h1c00_8000);
    drain();

    // Misaligned target: ADEF slot, no request until the next redirect
    br_redirect(32'h1c00_0102);
    chk("t5_redirect_req", 32'(last_req), 32'd0);
    tick();
    chk("t5_misaligned_req", 32'(last_req), 32'd0);
    tick();
    chk("t5_valid", 32'(last_valid), 32'd1);
    chk("t5_pop_n", 32'(pop_q.size()), 32'd1);
    chk("t5_adef", 32'(pop_at(0).adef), 32'd1);
    chk("t5_pc", pop_at(0).pc, 32'h1c00_0102);
    chk("t5_inst", pop_at(0).inst, 32'h0);
    repeat (3) tick();
    chk("t5_hold_req", 32'(last_req), 32'd0);
    chk("t5_hold_acc", 32'(acc_q.size()), 32'd0);
    chk("t5_hold_pop_n", 32'(pop_q.size()), 32'd1);
    wb_redirect_valid = 1'b1; wb_redirect_pc = 32'h1c00_8000;
    tick();
    wb_redirect_valid = 1'b0;
    tick();
    chk("t5_release_req", 32'(last_req), 32'd1);
    chk("t5_release_addr", last_addr, 32'h1c00_8000);
    drain();

    // Fetch stall with two requests in flight
    mem_en = 1'b0;
    br_redirect(32'h1c00_0300);
    repeat (2) tick();
    fetch_stall = 1'b1;
    mem_en = 1'b1;
    repeat (5) tick();
    chk("t6_acc_n", 32'(acc_q.size()), 32'd2);
    chk("t6_stall_req", 32'(last_req), 32'd0);
    chk("t6_pop_n", 32'(pop_q.size()), 32'd2);
    chk("t6_pop0", pop_at(0).pc, 32'h1c00_0300);
    chk("t6_pop1", pop_at(1).pc, 32'h1c00_0304);
    fetch_stall = 1'b0;
    acc_q.delete();
    tick();
    chk("t6_resume_req", 32'(last_req), 32'd1);
    chk("t6_resume_addr", last_addr, 32'h1c00_0308);
    drain();

    // Redirect coinciding with a live response
    mem_en = 1'b0;
    br_redirect(32'h1c00_0400);
    repeat (2) tick();
    mem_en = 1'b1;
    br_redirect(32'h1c00_0500);
    chk("t7_redirect_req", 32'(last_req), 32'd0);
    repeat (4) tick();
    chk("t7_pop_n", 32'(pop_q.size()), 32'd2);
    chk("t7_pop0", pop_at(0).pc, 32'h1c00_0500);
    chk("t7_pop1", pop_at(1).pc, 32'h1c00_0504);
    drain();

    // Redirect empties a non-empty IBUF
    id_ready = 1'b0;
    repeat (3) tick();
    chk("t8_filled", 32'(id_valid), 32'd1);
    br_redirect(32'h1c00_0700);
    chk("t8_flushed", 32'(id_valid), 32'd0);
    id_ready = 1'b1;
    repeat (4) tick();
    chk("t8_pop_n", 32'(pop_q.size()), 32'd2);
    chk("t8_pop0", pop_at(0).pc, 32'h1c00_0700);
    chk("t8_pop1", pop_at(1).pc, 32'h1c00_0704);
    drain();

    // Asynchronous reset mid-operation
    id_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("t9_rst_valid", 32'(id_valid), 32'd0);
    chk("t9_rst_req", 32'(inst_sram_req), 32'd0);
    chk("t9_rst_addr", inst_sram_addr, 32'h1c00_0000);
    mem_q.delete();
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    pop_q.delete();
    id_ready = 1'b1;
    tick();
    chk("t9_req", 32'(last_req), 32'd1);
    chk("t9_addr", last_addr, 32'h1c00_0000);
    repeat (3) tick();
    chk("t9_pop0", pop_at(0).pc, 32'h1c00_0000);
    chk("t9_pop1", pop_at(1).pc, 32'h1c00_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
